// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared types and widths for the divider flow-control wrapper
// Contents: TAG_W (result tag width), default operand widths, the result record
// and the wrapper's two-state flush/run type.
package divider_pkg;

    localparam int TAG_W      = 6;
    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;

    typedef struct packed {
        logic [TAG_W-1:0]      tag;
        logic [DIVIDEND_W-1:0] quotient;
        logic [DIVIDEND_W-1:0] remainder;
    } div_result_t;

    typedef enum logic {
        ST_FLUSH = 1'b0,
        ST_RUN   = 1'b1
    } flow_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered storage and full/empty flags
// Ports:
//   clock, reset_n      clock and asynchronous active-low reset
//   push, push_data     write request and data; a push while full with no pop is dropped
//   pop, pop_data       read request and head-of-queue data (valid while !empty)
//   full, empty         occupancy flags
module sync_fifo #(
    parameter int width = 38,
    parameter int depth = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_ok;
    logic             rd_ok;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts a push.
    assign rd_ok = pop && !empty;
    assign wr_ok = push && (!full || rd_ok);

    assign full     = (count == (AW+1)'(depth));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/divider_flow_control.sv
// rtl/divider_flow_control.sv - valid/ready wrapper with credits and result FIFO around pipelined_divider
// Ports:
//   clock, reset_n                     clock and asynchronous active-low reset
//   s_valid/s_ready/s_dividend/s_divisor   client request stream
//   div_input_valid/tag, div_dividend/divisor  to the divider
//   div_output_valid/tag, div_quotient/remainder  from the divider
//   m_valid/m_ready/m_tag/m_quotient/m_remainder  result stream
//   reserved_count                     results in flight plus results buffered
//   tag_error, overflow_error          sticky error flags
module divider_flow_control
    import divider_pkg::*;
#(
    parameter int dividend_width = 16,
    parameter int divisor_width  = 8,
    parameter int fifo_depth     = 32,
    parameter int div_latency    = dividend_width + 3
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [dividend_width-1:0] s_dividend,
    input  logic [divisor_width-1:0]  s_divisor,
    output logic                      div_input_valid,
    output logic [TAG_W-1:0]          div_input_tag,
    output logic [dividend_width-1:0] div_dividend,
    output logic [divisor_width-1:0]  div_divisor,
    input  logic                      div_output_valid,
    input  logic [TAG_W-1:0]          div_output_tag,
    input  logic [dividend_width-1:0] div_quotient,
    input  logic [dividend_width-1:0] div_remainder,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [TAG_W-1:0]          m_tag,
    output logic [dividend_width-1:0] m_quotient,
    output logic [dividend_width-1:0] m_remainder,
    output logic [6:0]                reserved_count,
    output logic                      tag_error,
    output logic                      overflow_error
);

    localparam int ENTRY_W = TAG_W + 2 * dividend_width;
    localparam int CNT_W   = $clog2(div_latency + 2);

    flow_state_t        state;
    logic [CNT_W-1:0]   flush_cnt;
    logic [TAG_W-1:0]   issue_tag;
    logic [TAG_W-1:0]   expect_tag;

    logic               issue;
    logic               pop;
    logic               capture;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] pop_data;

    // Credits cover both in-flight and buffered results, so an issued request
    // always has a FIFO slot waiting for it.
    assign s_ready = (state == ST_RUN) && (reserved_count < 7'(fifo_depth));
    assign issue   = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    assign div_input_valid = issue;
    assign div_input_tag   = issue_tag;
    assign div_dividend    = s_dividend;
    assign div_divisor     = s_divisor;

    // The divider has no reset; anything it emits before RUN is stale.
    assign capture   = (state == ST_RUN) && div_output_valid;
    assign push_data = {div_output_tag, div_quotient, div_remainder};

    assign m_valid     = !fifo_empty;
    assign m_tag       = pop_data[ENTRY_W-1 -: TAG_W];
    assign m_quotient  = pop_data[2*dividend_width-1 -: dividend_width];
    assign m_remainder = pop_data[dividend_width-1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_FLUSH;
            flush_cnt <= '0;
        end else begin
            case (state)
                ST_FLUSH: begin
                    // div_latency+1 cycles drains every stage of the divider pipeline.
                    if (flush_cnt == CNT_W'(div_latency)) begin
                        state <= ST_RUN;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            issue_tag      <= '0;
            expect_tag     <= '0;
            reserved_count <= '0;
            tag_error      <= 1'b0;
            overflow_error <= 1'b0;
        end else begin
            if (issue) begin
                issue_tag <= issue_tag + 1'b1;
            end
            case ({issue, pop})
                2'b10:   reserved_count <= reserved_count + 7'd1;
                2'b01:   reserved_count <= reserved_count - 7'd1;
                default: reserved_count <= reserved_count;
            endcase
            if (capture) begin
                expect_tag <= expect_tag + 1'b1;
                if (div_output_tag != expect_tag) begin
                    tag_error <= 1'b1;
                end
                if (fifo_full && !pop) begin
                    overflow_error <= 1'b1;
                end
            end
        end
    end

    sync_fifo #(
        .width (ENTRY_W),
        .depth (fifo_depth)
    ) u_result_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (capture),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
